// File: rtl/csa_mw_seq.sv
// Multi-word add/subtract sequencer for an external 4-bit carry-select adder.
// Feeds the adder one nibble per clock (LS nibble first) and carries through a register.
module csa_mw_seq #(
    parameter int NW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            SUB,
    input  logic [4*NW-1:0] OPA,
    input  logic [4*NW-1:0] OPB,
    output logic [3:0]      CSA_A,
    output logic [3:0]      CSA_B,
    output logic            CSA_CIN,
    input  logic [3:0]      CSA_S,
    input  logic            CSA_COUT,
    output logic [4*NW-1:0] RES,
    output logic            COUT,
    output logic            OVF,
    output logic            ZERO,
    output logic            BUSY,
    output logic            DONE
);

    localparam int W  = 4 * NW;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          sub_r;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_next;
    logic          ovf_nib;

    // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the initial carry.
    assign CSA_A   = a_sh[3:0];
    assign CSA_B   = b_sh[3:0] ^ {4{sub_r}};
    assign CSA_CIN = carry;

    // Sign-bit overflow only matters on the most-significant nibble.
    assign ovf_nib = (CSA_A[3] == CSA_B[3]) && (CSA_S[3] != CSA_A[3]);

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        res_next          = RES >> 4;
        res_next[W-1 -: 4] = CSA_S;
    end

    always_ff @(posedge CLK) begin
        // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            // NOTE: the operand shift registers are plain flops, not a RAM, so they are reset like any other state.
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            sub_r <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            RES   <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
            ZERO  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        a_sh  <= OPA;
                        b_sh  <= OPB;
                        sub_r <= SUB;
                        carry <= SUB;
                        cnt   <= '0;
                        RES   <= '0;
                        COUT  <= 1'b0;
                        OVF   <= 1'b0;
                        ZERO  <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    RES   <= res_next;
                    carry <= CSA_COUT;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        COUT  <= CSA_COUT;
                        OVF   <= ovf_nib;
                        ZERO  <= (res_next == '0);
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end

                FIN: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mw_seq.sv
// Self-checking bench for csa_mw_seq: table vectors and random ops through a scoreboard,
// plus hand sequences for back-to-back START, mid-run reset and the NW=1 case.
module tb_csa_mw_seq;

    localparam int NW = 4;
    localparam int W  = 4 * NW;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // NW=4 instance
    logic         RST, START, SUB;
    logic [W-1:0] OPA, OPB, RES;
    logic [3:0]   CSA_A, CSA_B, CSA_S;
    logic         CSA_CIN, CSA_COUT;
    logic         COUT, OVF, ZERO, BUSY, DONE;

    // NW=1 instance
    logic         START1, SUB1;
    logic [3:0]   OPA1, OPB1, RES1;
    logic [3:0]   CSA_A1, CSA_B1, CSA_S1;
    logic         CSA_CIN1, CSA_COUT1;
    logic         COUT1, OVF1, ZERO1, BUSY1, DONE1;

    // Behavioural stand-in for the shared combinational 4-bit adder.
    assign {CSA_COUT, CSA_S}   = {1'b0, CSA_A} + {1'b0, CSA_B} + {4'b0, CSA_CIN};
    assign {CSA_COUT1, CSA_S1} = {1'b0, CSA_A1} + {1'b0, CSA_B1} + {4'b0, CSA_CIN1};

    csa_mw_seq #(.NW(NW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .OPA(OPA), .OPB(OPB),
        .CSA_A(CSA_A), .CSA_B(CSA_B), .CSA_CIN(CSA_CIN), .CSA_S(CSA_S), .CSA_COUT(CSA_COUT),
        .RES(RES), .COUT(COUT), .OVF(OVF), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
    );

    csa_mw_seq #(.NW(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START1), .SUB(SUB1), .OPA(OPA1), .OPB(OPB1),
        .CSA_A(CSA_A1), .CSA_B(CSA_B1), .CSA_CIN(CSA_CIN1), .CSA_S(CSA_S1), .CSA_COUT(CSA_COUT1),
        .RES(RES1), .COUT(COUT1), .OVF(OVF1), .ZERO(ZERO1), .BUSY(BUSY1), .DONE(DONE1)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb[$];
    vec_t mon_e;
    vec_t last_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t         r;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        r.sub  = s;
        r.a    = a;
        r.b    = b;
        r.res  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        r.zero = (full[W-1:0] == '0);
        return r;
    endfunction

    // Scoreboard consumer: every DONE pulse must match the oldest outstanding operation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res",  32'(RES),  32'(mon_e.res));
                check("cout", 32'(COUT), 32'(mon_e.cout));
                check("ovf",  32'(OVF),  32'(mon_e.ovf));
                check("zero", 32'(ZERO), 32'(mon_e.zero));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int busy_n;
        int done_n;
        int done_k;
        @(negedge CLK);
        START = 1'b1;
        SUB   = v.sub;
        OPA   = v.a;
        OPB   = v.b;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        START  = 1'b0;
        SUB    = ~v.sub;
        OPA    = ~v.a;
        OPB    = 16'($urandom);
        busy_n = 0;
        done_n = 0;
        done_k = -1;
        for (int k = 0; k <= NW + 1; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
            end
            if (BUSY === 1'b1) busy_n++;
            if (DONE === 1'b1) begin
                done_n++;
                done_k = k;
            end
        end
        check("busy_cycles", busy_n, NW);
        check("done_latency", done_k, NW);
        check("done_count", done_n, 1);
    endtask

    task automatic run_op1(input logic s, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eres, input logic ec, input logic eo, input logic ez);
        @(negedge CLK);
        START1 = 1'b1;
        SUB1   = s;
        OPA1   = a;
        OPB1   = b;
        @(posedge CLK);
        #1;
        START1 = 1'b0;
        check("nw1_busy", 32'(BUSY1), 32'd1);
        check("nw1_no_early_done", 32'(DONE1), 32'd0);
        @(posedge CLK);
        #1;
        check("nw1_done", 32'(DONE1), 32'd1);
        check("nw1_res",  32'(RES1),  32'(eres));
        check("nw1_cout", 32'(COUT1), 32'(ec));
        check("nw1_ovf",  32'(OVF1),  32'(eo));
        check("nw1_zero", 32'(ZERO1), 32'(ez));
        @(posedge CLK);
        #1;
        check("nw1_done_drop", 32'(DONE1), 32'd0);
        check("nw1_busy_drop", 32'(BUSY1), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        int dn;
        int dk1;
        int dk2;

        tbl[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};

        RST = 1'b1; START = 1'b0; SUB = 1'b0; OPA = '0; OPB = '0;
        START1 = 1'b0; SUB1 = 1'b0; OPA1 = '0; OPB1 = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_res",  32'(RES),  32'd0);
        check("rst_flags", {28'd0, COUT, OVF, ZERO, BUSY}, 32'd0);
        check("rst_done", 32'(DONE), 32'd0);

        foreach (tbl[i]) run_op(tbl[i]);

        // Result and flags must hold through idle cycles.
        last_v = tbl[7];
        repeat (3) @(posedge CLK);
        #1;
        check("hold_res",  32'(RES),  32'(last_v.res));
        check("hold_zero", 32'(ZERO), 32'(last_v.zero));
        check("hold_cout", 32'(COUT), 32'(last_v.cout));

        for (int i = 0; i < 20; i++) begin
            run_op(model(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom)));
        end

        // START held high: second op must begin on the first IDLE cycle with the new operands.
        @(negedge CLK);
        START = 1'b1; SUB = 1'b0; OPA = 16'h1111; OPB = 16'h2222;
        sb.push_back(model(1'b0, 16'h1111, 16'h2222));
        sb.push_back(model(1'b0, 16'h5555, 16'h0001));
        @(posedge CLK);
        #1;
        OPA = 16'h5555; OPB = 16'h0001;
        dn = 0; dk1 = -1; dk2 = -1;
        for (int k = 1; k <= 2 * NW + 4; k++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) begin
                dn++;
                if (dk1 < 0) dk1 = k;
                else dk2 = k;
            end
            if (k == NW + 2) begin
                check("b2b_restart_busy", 32'(BUSY), 32'd1);
                START = 1'b0;
            end
        end
        check("b2b_done_count", dn, 2);
        check("b2b_first_done", dk1, NW);
        check("b2b_second_done", dk2, 2 * NW + 2);

        // Reset on the second RUN cycle abandons the operation.
        @(negedge CLK);
        START = 1'b1; SUB = 1'b0; OPA = 16'hABCD; OPB = 16'h1357;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst_res", 32'(RES), 32'd0);
        check("midrst_flags", {27'd0, COUT, OVF, ZERO, BUSY, DONE}, 32'd0);
        dn = 0;
        for (int k = 0; k < NW + 2; k++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) dn++;
        end
        check("midrst_no_done", dn, 0);
        run_op(model(1'b0, 16'h0001, 16'h0001));

        run_op1(1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        run_op1(1'b1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0);
        run_op1(1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
        run_op1(1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0);

        repeat (2) @(posedge CLK);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
